// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package instr_mem_loader_pkg;

  localparam int LANE_W         = 8;
  localparam int WIDTH_DEFAULT  = 32;
  localparam int BYTES_PER_WORD = WIDTH_DEFAULT / LANE_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_CHECK = 3'd4
  } state_e;

  function automatic int bytes_per_word(input int width);
    return width / LANE_W;
  endfunction

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Collects accepted bytes into a little-endian word; word_complete flags the final lane.
module loader_word_assembler
  import instr_mem_loader_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             accept,
  input  logic [7:0]       byte_in,
  output logic [WIDTH-1:0] word,
  output logic             word_complete
);

  localparam int BPW   = bytes_per_word(WIDTH);
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IDX_W-1:0] byte_idx;

  assign word_complete = accept && (byte_idx == IDX_W'(BPW - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx <= '0;
      word     <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (accept) begin
      word[LANE_W*int'(byte_idx) +: LANE_W] <= byte_in;
      // Wrap on the last lane so the next word starts at lane 0 after WRITE.
      byte_idx <= word_complete ? '0 : byte_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: byte stream -> instruction memory, holds the CPU in reset until loaded.
// Optional trailing checksum byte enabled by INSTR_MEM_LOADER_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | waiting for start (after reset, reject or abort)
// RECV    | accepting bytes of the current word
// WRITE   | one-cycle memory write of the assembled word
// CHECK   | accepting the checksum byte (checksum build only)
// DONE    | program loaded, CPU released
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W+1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  state_e state, state_nxt;

  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  word_idx;
  logic [ADDR_W+1:0] addr_hold;
  logic [WIDTH-1:0]  wdata_hold;
  logic [WIDTH-1:0]  asm_word;
  logic              error_q;
  logic              start_ok, start_zero, start_bad, start_load;
  logic              in_load, abort_act, accept, recv_accept;
  logic              word_complete, last_word;

  assign start_ok    = start && (state == S_IDLE || state == S_DONE);
  assign start_zero  = start_ok && (word_count == '0);
  assign start_bad   = start_ok && (word_count > CNT_W'(DEPTH));
  assign start_load  = start_ok && !start_zero && !start_bad;
  assign in_load     = (state == S_RECV) || (state == S_WRITE) || (state == S_CHECK);
  assign abort_act   = abort && in_load;
  // Ready drops under abort so the source never sees a byte consumed that was discarded.
  assign byte_ready  = ((state == S_RECV) || (state == S_CHECK)) && !abort;
  assign accept      = byte_valid && byte_ready;
  assign recv_accept = accept && (state == S_RECV);
  assign last_word   = (word_idx + CNT_W'(1)) == count_q;

  loader_word_assembler #(.WIDTH(WIDTH)) u_asm (
    .clk           (clk),
    .reset         (reset),
    .clear         (start_ok),
    .accept        (recv_accept),
    .byte_in       (byte_in),
    .word          (asm_word),
    .word_complete (word_complete)
  );

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       csum_ok, csum_fail;

  assign csum_ok   = (state == S_CHECK) && accept && (byte_in == sum_q);
  assign csum_fail = (state == S_CHECK) && accept && (byte_in != sum_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           sum_q <= '0;
    else if (start_ok)    sum_q <= '0;
    else if (recv_accept) sum_q <= sum_q + byte_in;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_zero)      state_nxt = S_DONE;
        else if (start_bad)  state_nxt = S_IDLE;
        else if (start_load) state_nxt = S_RECV;
      end
      S_RECV: begin
        if (abort)              state_nxt = S_IDLE;
        else if (word_complete) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (abort) state_nxt = S_IDLE;
        else if (last_word) begin
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
          state_nxt = S_CHECK;
`else
          state_nxt = S_DONE;
`endif
        end else state_nxt = S_RECV;
      end
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (abort)          state_nxt = S_IDLE;
        else if (csum_ok)   state_nxt = S_DONE;
        else if (csum_fail) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      word_idx   <= '0;
      error_q    <= 1'b0;
      addr_hold  <= '0;
      wdata_hold <= '0;
    end else begin
      if (start_zero) begin
        error_q <= 1'b0;
      end else if (start_bad) begin
        error_q <= 1'b1;
      end else if (start_load) begin
        count_q  <= word_count;
        word_idx <= '0;
        error_q  <= 1'b0;
      end
      if (state == S_WRITE) begin
        word_idx   <= word_idx + CNT_W'(1);
        addr_hold  <= mem_addr;
        wdata_hold <= asm_word;
      end
      if (abort_act) error_q <= 1'b1;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
      if (csum_fail) error_q <= 1'b1;
`endif
    end
  end

  // Address/data are live during WRITE and otherwise replay the last write.
  assign mem_we    = (state == S_WRITE);
  assign mem_addr  = mem_we ? {word_idx[ADDR_W-1:0], 2'b00} : addr_hold;
  assign mem_wdata = mem_we ? asm_word : wdata_hold;
  assign busy      = in_load;
  assign done      = (state == S_DONE);
  assign cpu_hold  = (state != S_DONE);
  assign error     = error_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: directed scenarios plus randomized loads vs a byte-stream model.
module tb_instr_mem_loader;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic              abort;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W+1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;

  int n_cmp = 0;
  int n_err = 0;

  logic [ADDR_W+1:0] wr_addr_q[$];
  logic [WIDTH-1:0]  wr_data_q[$];

  instr_mem_loader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .abort      (abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset === 1'b1 && mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", byte_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
  endtask

  task automatic do_start(input int wc);
    @(negedge clk);
    start = 1'b1;
    word_count = (ADDR_W+1)'(wc);
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: always valid, 1: valid toggles every cycle, 2: random valid.
  // Returns at the negedge after the last accepted byte (plus the WRITE check when a word closed).
  task automatic send_bytes(input logic [7:0] b[$], input int mode);
    int  i = 0;
    int  cyc = 0;
    bit  pend = 0;
    while (i < b.size() && cyc < 3000) begin
      byte_in = b[i];
      byte_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : ($urandom_range(0, 3) != 0);
      #1;
      if (pend) begin
        chk("we_latency", mem_we, 1);
        chk("ready_in_write", byte_ready, 0);
        pend = 0;
      end else begin
        chk("ready_in_recv", byte_ready, 1);
        chk("no_stray_we", mem_we, 0);
      end
      if (byte_valid && byte_ready) begin
        i++;
        if (i % 4 == 0) pend = 1;
      end
      @(negedge clk);
      cyc++;
    end
    byte_valid = 1'b0;
    chk("send_budget", cyc < 3000, 1);
    if (pend) begin
      #1;
      chk("we_latency_last", mem_we, 1);
      chk("ready_in_write_last", byte_ready, 0);
    end
  endtask

  // Full load of prog (size multiple of 4); bad_sum corrupts the checksum byte when that feature exists.
  task automatic run_load(input logic [7:0] prog[$], input int mode, input bit bad_sum);
    int         nw = prog.size() / 4;
    logic [7:0] sum = 8'h00;
    logic [31:0] w;
    foreach (prog[k]) sum = sum + prog[k];
    wr_addr_q.delete();
    wr_data_q.delete();
    do_start(nw);
    send_bytes(prog, mode);
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    @(negedge clk);
    #1;
    chk("check_ready", byte_ready, 1);
    chk("check_busy", busy, 1);
    byte_in = bad_sum ? sum + 8'h01 : sum;
    byte_valid = 1'b1;
`endif
    @(negedge clk);
    byte_valid = 1'b0;
    #1;
    chk("end_done", done, !bad_sum);
    chk("end_hold", cpu_hold, bad_sum);
    chk("end_busy", busy, 0);
    chk("end_error", error, bad_sum);
    chk("wr_count", wr_addr_q.size(), nw);
    for (int k = 0; k < nw && k < wr_addr_q.size(); k++) begin
      w = {prog[4*k+3], prog[4*k+2], prog[4*k+1], prog[4*k]};
      chk("wr_addr", wr_addr_q[k], 4 * k);
      chk("wr_data", wr_data_q[k], w);
    end
    chk("hold_addr", mem_addr, 4 * (nw - 1));
    chk("hold_wdata", mem_wdata, {prog[4*nw-1], prog[4*nw-2], prog[4*nw-3], prog[4*nw-4]});
  endtask

  function automatic void rand_prog(output logic [7:0] p[$], input int nw);
    p.delete();
    for (int k = 0; k < 4 * nw; k++) p.push_back(8'($urandom_range(0, 255)));
  endfunction

  initial begin
    logic [7:0] prog[$];
    logic [7:0] part[$];

    reset = 1'b0;
    start = 1'b0;
    word_count = '0;
    abort = 1'b0;
    byte_in = 8'h00;
    byte_valid = 1'b0;

    #12;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b1;

    prog = '{8'h01, 8'h00, 8'hA0, 8'hE3, 8'h02, 8'h10, 8'hA0, 8'hE3};
    run_load(prog, 0, 0);
    chk("directed_word0", (wr_data_q.size() > 0) ? wr_data_q[0] : 32'h0, 32'hE3A00001);

    rand_prog(prog, 1);
    run_load(prog, 1, 0);

    for (int it = 0; it < 5; it++) begin
      rand_prog(prog, $urandom_range(1, 5));
      run_load(prog, 2, 0);
    end

    wr_addr_q.delete();
    do_start(0);
    #1;
    chk("zero_done", done, 1);
    chk("zero_hold", cpu_hold, 0);
    chk("zero_busy", busy, 0);
    chk("zero_no_we", wr_addr_q.size(), 0);
    do_start(65);
    #1;
    chk("ovf_error", error, 1);
    chk("ovf_hold", cpu_hold, 1);
    chk("ovf_done", done, 0);
    chk("ovf_busy", busy, 0);
    chk("ovf_ready", byte_ready, 0);

    rand_prog(prog, 1);
    run_load(prog, 0, 0);

    wr_addr_q.delete();
    rand_prog(part, 1);
    part = part[0:1];
    do_start(1);
    send_bytes(part, 0);
    abort = 1'b1;
    byte_in = 8'h5A;
    byte_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    byte_valid = 1'b0;
    #1;
    chk("abort_error", error, 1);
    chk("abort_busy", busy, 0);
    chk("abort_hold", cpu_hold, 1);
    chk("abort_ready", byte_ready, 0);
    chk("abort_no_we", wr_addr_q.size(), 0);
    rand_prog(prog, 1);
    run_load(prog, 2, 0);

    rand_prog(part, 3);
    part = part[0:5];
    do_start(3);
    send_bytes(part, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    reset = 1'b1;
    rand_prog(prog, 3);
    run_load(prog, 0, 0);

    rand_prog(prog, 64);
    run_load(prog, 0, 0);

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    prog = '{8'h10, 8'h20, 8'h30, 8'h40};
    run_load(prog, 0, 0);
    run_load(prog, 0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
